// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator-side controller for an 8-bit combinational ALU. Accepts load and
// ALU-operation commands over a valid/ready handshake, drives the ALU from
// registered operands, writes the result back into a small register file and
// returns the result plus flags over a second valid/ready handshake.
// One command is in flight at a time (IDLE -> [EXEC] -> RESP -> IDLE).
//
// Optional feature: define ALU_SEQ_STICKY_EN to add sticky zero / A>=B flags
// (ports sticky_clr, sticky_zero, sticky_c). Without the macro those ports
// and their logic are absent.

module alu_cmd_sequencer #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_opcode,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic [7:0]        cmd_imm,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              rsp_zero,
    output logic              rsp_c,
    output logic              rsp_carry,
    // ALU initiator side
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_opcode,
    output logic              alu_carry_in,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry_out,
    input  logic              alu_zero_flag,
    input  logic              alu_c_flag
`ifdef ALU_SEQ_STICKY_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_zero,
    output logic              sticky_c
`endif
);

    localparam int          NREG   = 1 << REG_AW;
    localparam logic [2:0]  OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [7:0]          regs_q [NREG];
    logic [7:0]          regs_d [NREG];
    logic [REG_AW-1:0]   dst_q,       dst_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q,  rsp_data_d;
    logic                rsp_zero_q,  rsp_zero_d;
    logic                rsp_c_q,     rsp_c_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [7:0]          alu_a_q,     alu_a_d;
    logic [7:0]          alu_b_q,     alu_b_d;
    logic [2:0]          alu_op_q,    alu_op_d;
    logic                alu_cin_q,   alu_cin_d;

    logic                cmd_fire;
    logic                rsp_fire;

    assign cmd_fire = cmd_valid & cmd_ready_q;
    assign rsp_fire = rsp_valid_q & rsp_ready;

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        dst_d       = dst_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_c_d     = rsp_c_q;
        rsp_carry_d = rsp_carry_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_load) begin
                        // Loads complete immediately; flags follow the load rules.
                        regs_d[cmd_dst] = cmd_imm;
                        rsp_data_d      = cmd_imm;
                        rsp_zero_d      = (cmd_imm == 8'h00);
                        rsp_c_d         = 1'b0;
                        rsp_carry_d     = 1'b0;
                        rsp_valid_d     = 1'b1;
                        state_d         = RESP;
                    end else begin
                        // Operands are read here, before any write-back, so
                        // overlapping src/dst indices are well defined.
                        alu_a_d   = regs_q[cmd_src_a];
                        alu_b_d   = regs_q[cmd_src_b];
                        alu_op_d  = cmd_opcode;
                        alu_cin_d = (cmd_opcode == OP_SUB);
                        dst_d     = cmd_dst;
                        state_d   = EXEC;
                    end
                end
            end

            EXEC: begin
                // ALU inputs have been stable since the previous edge.
                rsp_data_d     = alu_result;
                rsp_zero_d     = alu_zero_flag;
                rsp_c_d        = alu_c_flag;
                rsp_carry_d    = alu_carry_out;
                regs_d[dst_q]  = alu_result;
                rsp_valid_d    = 1'b1;
                state_d        = RESP;
            end

            RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Register all sequencer state; reset discards any command or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
            dst_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_zero_q  <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_carry_q <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= 3'b000;
            alu_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            dst_q       <= dst_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_c_q     <= rsp_c_d;
            rsp_carry_q <= rsp_carry_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_c        = rsp_c_q;
    assign rsp_carry    = rsp_carry_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_op_q;
    assign alu_carry_in = alu_cin_q;

`ifdef ALU_SEQ_STICKY_EN
    logic sticky_zero_q, sticky_zero_d;
    logic sticky_c_q,    sticky_c_d;
    logic in_exec;

    assign in_exec = (state_q == EXEC);

    // Sticky flags: set from the ALU in EXEC only; a same-cycle set beats clear.
    always_comb begin
        sticky_zero_d = (sticky_zero_q & ~sticky_clr) | (in_exec & alu_zero_flag);
        sticky_c_d    = (sticky_c_q    & ~sticky_clr) | (in_exec & alu_c_flag);
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_zero_q <= 1'b0;
            sticky_c_q    <= 1'b0;
        end else begin
            sticky_zero_q <= sticky_zero_d;
            sticky_c_q    <= sticky_c_d;
        end
    end

    assign sticky_zero = sticky_zero_q;
    assign sticky_c    = sticky_c_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed commands against a behavioural
// model of the 8-bit ALU, with hand-computed expected responses.
// Sticky-flag checks are compiled in when ALU_SEQ_STICKY_EN is defined.

module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_opcode;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_c;
    logic       rsp_carry;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic       alu_carry_in;
    logic [7:0] alu_result;
    logic       alu_carry_out;
    logic       alu_zero_flag;
    logic       alu_c_flag;
`ifdef ALU_SEQ_STICKY_EN
    logic       sticky_clr;
    logic       sticky_zero;
    logic       sticky_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer #(.REG_AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_load      (cmd_load),
        .cmd_opcode    (cmd_opcode),
        .cmd_dst       (cmd_dst),
        .cmd_src_a     (cmd_src_a),
        .cmd_src_b     (cmd_src_b),
        .cmd_imm       (cmd_imm),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_zero      (rsp_zero),
        .rsp_c         (rsp_c),
        .rsp_carry     (rsp_carry),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .alu_zero_flag (alu_zero_flag),
        .alu_c_flag    (alu_c_flag)
`ifdef ALU_SEQ_STICKY_EN
        ,
        .sticky_clr    (sticky_clr),
        .sticky_zero   (sticky_zero),
        .sticky_c      (sticky_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU driven by the sequencer
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'h000;
        case (alu_opcode)
            3'b000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
            3'b001: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_carry_in};
            3'b010: alu_sum = {1'b0, alu_a & alu_b};
            3'b011: alu_sum = {1'b0, alu_a | alu_b};
            3'b100: alu_sum = {1'b0, alu_a ^ alu_b};
            3'b101: alu_sum = 9'h000;
            3'b110: alu_sum = {alu_a, 1'b0};
            default: alu_sum = {alu_b, 1'b0};
        endcase
    end
    assign alu_result    = alu_sum[7:0];
    assign alu_carry_out = alu_sum[8];
    assign alu_zero_flag = (alu_sum[7:0] == 8'h00);
    assign alu_c_flag    = (alu_a >= alu_b);

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for and consume its response.
    task automatic run_op(input logic ld, input logic [2:0] op, input logic [1:0] d,
                          input logic [1:0] a, input logic [1:0] b, input logic [7:0] imm,
                          output logic [7:0] data, output logic z, output logic c,
                          output logic cy, output int lat, output logic cin_x);
        int n;
        cmd_load   = ld;
        cmd_opcode = op;
        cmd_dst    = d;
        cmd_src_a  = a;
        cmd_src_b  = b;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk_val("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cin_x = alu_carry_in;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) chk_val("rsp_timeout", 32'd0, 32'd1);
        data = rsp_data;
        z    = rsp_zero;
        c    = rsp_c;
        cy   = rsp_carry;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Read a register back through an OR of the register with itself.
    task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
        logic z, c, cy, cx;
        int   lat;
        run_op(1'b0, 3'b011, idx, idx, idx, 8'h00, val, z, c, cy, lat, cx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       z, c, cy, cx;
        int         lat;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_load   = 1'b0;
        cmd_opcode = 3'b000;
        cmd_dst    = 2'd0;
        cmd_src_a  = 2'd0;
        cmd_src_b  = 2'd0;
        cmd_imm    = 8'h00;
        rsp_ready  = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk_val("rst_cmd_ready", cmd_ready, 1);
        chk_val("rst_rsp_valid", rsp_valid, 0);
        chk_val("rst_rsp_data",  rsp_data, 0);
        chk_val("rst_rsp_flags", {rsp_zero, rsp_c, rsp_carry}, 0);
        chk_val("rst_alu_ab",    {alu_a, alu_b}, 0);
        chk_val("rst_alu_op",    {alu_opcode, alu_carry_in}, 0);
`ifdef ALU_SEQ_STICKY_EN
        chk_val("rst_sticky", {sticky_zero, sticky_c}, 0);
`endif

        // Loads and add
        run_op(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, d, z, c, cy, lat, cx);
        chk_val("ld_r0_data", d, 8'h05);
        chk_val("ld_r0_lat",  lat, 1);
        chk_val("ld_r0_flags", {z, c, cy}, 3'b000);
        run_op(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h03, d, z, c, cy, lat, cx);
        chk_val("ld_r1_data", d, 8'h03);
        run_op(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, d, z, c, cy, lat, cx);
        chk_val("add_data",  d, 8'h08);
        chk_val("add_flags", {z, c, cy}, 3'b010);
        chk_val("add_lat",   lat, 2);
        chk_val("add_cin",   cx, 0);
        read_reg(2'd2, d);
        chk_val("rd_r2", d, 8'h08);

        // Subtract with negative result
        run_op(1'b0, 3'b001, 2'd3, 2'd1, 2'd0, 8'h00, d, z, c, cy, lat, cx);
        chk_val("sub_cin",   cx, 1);
        chk_val("sub_data",  d, 8'hFE);
        chk_val("sub_flags", {z, c, cy}, 3'b000);

        // Wrap-around add and self-subtract
        run_op(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'hFF, d, z, c, cy, lat, cx);
        run_op(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h01, d, z, c, cy, lat, cx);
        run_op(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, d, z, c, cy, lat, cx);
        chk_val("wrap_data",  d, 8'h00);
        chk_val("wrap_flags", {z, c, cy}, 3'b111);
        run_op(1'b0, 3'b001, 2'd0, 2'd0, 2'd0, 8'h00, d, z, c, cy, lat, cx);
        chk_val("selfsub_data",  d, 8'h00);
        chk_val("selfsub_flags", {z, c, cy}, 3'b111);
        read_reg(2'd0, d);
        chk_val("rd_r0_selfsub", d, 8'h00);

        // Load of zero: zero flag set, other flags cleared
        run_op(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h00, d, z, c, cy, lat, cx);
        chk_val("ld_zero_flags", {z, c, cy}, 3'b100);

        // Response backpressure with a second command waiting
        cmd_load  = 1'b1;
        cmd_dst   = 2'd1;
        cmd_imm   = 8'h5A;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_dst = 2'd2;
        cmd_imm = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_val("bp_rsp_valid", rsp_valid, 1);
            chk_val("bp_rsp_data",  rsp_data, 8'h5A);
            chk_val("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk_val("bp_idle_ready", cmd_ready, 1);
        chk_val("bp_idle_valid", rsp_valid, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk_val("bp_next_valid", rsp_valid, 1);
        chk_val("bp_next_data",  rsp_data, 8'h11);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset while in EXEC
        cmd_load   = 1'b0;
        cmd_opcode = 3'b000;
        cmd_dst    = 2'd3;
        cmd_src_a  = 2'd1;
        cmd_src_b  = 2'd1;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk_val("exec_alu_a", alu_a, 8'h5A);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_val("exec_rst_valid", rsp_valid, 0);
        chk_val("exec_rst_ready", cmd_ready, 1);
        chk_val("exec_rst_alu_a", alu_a, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), d);
            chk_val("exec_rst_reg", d, 8'h00);
        end

        // Shift and logic operations
        run_op(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h81, d, z, c, cy, lat, cx);
        run_op(1'b0, 3'b110, 2'd1, 2'd0, 2'd0, 8'h00, d, z, c, cy, lat, cx);
        chk_val("shl_data",  d, 8'h02);
        chk_val("shl_carry", cy, 1);
        run_op(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h0F, d, z, c, cy, lat, cx);
        run_op(1'b0, 3'b100, 2'd3, 2'd0, 2'd2, 8'h00, d, z, c, cy, lat, cx);
        chk_val("xor_data",  d, 8'h8E);
        chk_val("xor_flags", {z, c, cy}, 3'b010);
        run_op(1'b0, 3'b010, 2'd3, 2'd0, 2'd2, 8'h00, d, z, c, cy, lat, cx);
        chk_val("and_data", d, 8'h01);

`ifdef ALU_SEQ_STICKY_EN
        // Sticky flags
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk_val("sticky_clr0", {sticky_zero, sticky_c}, 0);
        run_op(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, d, z, c, cy, lat, cx);
        run_op(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h05, d, z, c, cy, lat, cx);
        run_op(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h03, d, z, c, cy, lat, cx);
        chk_val("sticky_load_noeffect", {sticky_zero, sticky_c}, 0);
        run_op(1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 8'h00, d, z, c, cy, lat, cx);
        chk_val("sticky_sub_data", d, 8'h00);
        chk_val("sticky_set", {sticky_zero, sticky_c}, 2'b11);
        run_op(1'b0, 3'b000, 2'd3, 2'd0, 2'd2, 8'h00, d, z, c, cy, lat, cx);
        chk_val("sticky_persist_data", d, 8'h08);
        chk_val("sticky_persist", sticky_zero, 1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk_val("sticky_cleared", {sticky_zero, sticky_c}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
